// File: rtl/mdu_div_seq_pkg.sv
// mdu_div_seq_pkg: shared widths, FSM encoding and operand-extension helpers for the divider.
package mdu_div_seq_pkg;
    localparam int XLEN = 64;
    localparam int DIV_CNT_W = 7;
    typedef enum logic [1:0] {DIV_IDLE, DIV_DIV, DIV_FIX, DIV_DONE} div_state_e;
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction
    function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
        return {{(XLEN-32){1'b0}}, v};
    endfunction
    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic s);
        return (s && v[XLEN-1]) ? -v : v;
    endfunction
endpackage

// File: rtl/mdu_div_seq_if.sv
// mdu_div_seq_if: operand/result valid-ready bundle between EXE issue and the divider.
interface mdu_div_seq_if import mdu_div_seq_pkg::*; ();
    logic in_valid, in_ready, div_signed, div_word;
    logic [XLEN-1:0] dividend, divisor;
    logic out_valid, out_ready;
    logic [XLEN-1:0] quotient, remainder;
    modport master (output in_valid, div_signed, div_word, dividend, divisor, out_ready,
                    input in_ready, out_valid, quotient, remainder);
    modport slave (input in_valid, div_signed, div_word, dividend, divisor, out_ready,
                   output in_ready, out_valid, quotient, remainder);
endinterface

// File: rtl/mdu_div_seq_step.sv
// div_restore_step: one combinational restoring-division iteration on magnitudes.
module div_restore_step import mdu_div_seq_pkg::*; (
    input  logic [XLEN-1:0] r,
    input  logic [XLEN-1:0] q,
    input  logic [XLEN-1:0] d,
    output logic [XLEN-1:0] r_nx,
    output logic [XLEN-1:0] q_nx
);
    logic [XLEN:0] sh, trial;
    always_comb begin
        sh    = {r, q[XLEN-1]};
        trial = sh - {1'b0, d};
        r_nx  = trial[XLEN] ? sh[XLEN-1:0] : trial[XLEN-1:0];
        q_nx  = {q[XLEN-2:0], ~trial[XLEN]};
    end
endmodule

// File: rtl/mdu_div_seq.sv
// mdu_div_seq: iterative radix-2 restoring DIV/DIVU/REM/REMU(+W) unit for RV64 EXE.
// Define DIV_EARLY_OUT_EN to finish |dividend| < |divisor| in the accept cycle.
module mdu_div_seq import mdu_div_seq_pkg::*; (
    input logic clock,
    input logic reset,
    input logic flush,
    mdu_div_seq_if.slave bus
);
    div_state_e state_q, state_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] r_q, r_d, r_step, q_q, q_d, q_step, d_q, d_d;
    logic [XLEN-1:0] quot_q, quot_d, rem_q, rem_d;
    logic q_neg_q, q_neg_d, r_neg_q, r_neg_d, word_q, word_d;
    logic [XLEN-1:0] a, b, ma, mb, mn, res_a, fq, fr;
    logic accept, dz, ovf, early, fast;

    div_restore_step u_step (.r(r_q), .q(q_q), .d(d_q), .r_nx(r_step), .q_nx(q_step));

    always_comb begin
        a      = bus.div_word ? (bus.div_signed ? sext32(bus.dividend[31:0]) : zext32(bus.dividend[31:0])) : bus.dividend;
        b      = bus.div_word ? (bus.div_signed ? sext32(bus.divisor[31:0]) : zext32(bus.divisor[31:0])) : bus.divisor;
        res_a  = bus.div_word ? sext32(bus.dividend[31:0]) : bus.dividend;
        mn     = bus.div_word ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        ma     = abs_val(a, bus.div_signed);
        mb     = abs_val(b, bus.div_signed);
        dz     = b == '0;
        ovf    = bus.div_signed && a == mn && &b;
`ifdef DIV_EARLY_OUT_EN
        early  = !dz && ma < mb;
`else
        early  = 1'b0;
`endif
        fast   = dz || ovf || early;
        accept = state_q == DIV_IDLE && bus.in_valid && !flush;
        fq     = q_neg_q ? -q_q : q_q;
        fr     = r_neg_q ? -r_q : r_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_IDLE: state_d = accept ? (fast ? DIV_DONE : DIV_DIV) : DIV_IDLE;
            DIV_DIV:  state_d = cnt_q == DIV_CNT_W'(1) ? DIV_FIX : DIV_DIV;
            DIV_FIX:  state_d = DIV_DONE;
            DIV_DONE: state_d = bus.out_ready ? DIV_IDLE : DIV_DONE;
            default:  state_d = DIV_IDLE;
        endcase
        if (flush) state_d = DIV_IDLE;
    end

    always_comb begin
        bus.in_ready  = state_q == DIV_IDLE;
        bus.out_valid = state_q == DIV_DONE;
        bus.quotient  = quot_q;
        bus.remainder = rem_q;
    end

    always_comb begin
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        word_d  = word_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        if (accept) begin
            word_d  = bus.div_word;
            q_neg_d = bus.div_signed & (a[XLEN-1] ^ b[XLEN-1]);
            r_neg_d = bus.div_signed & a[XLEN-1];
            r_d     = '0;
            // word dividends sit in the top half so the MSB-first shift starts at bit 31
            q_d     = bus.div_word ? {ma[31:0], {(XLEN-32){1'b0}}} : ma;
            d_d     = mb;
            cnt_d   = fast ? '0 : (bus.div_word ? DIV_CNT_W'(32) : DIV_CNT_W'(XLEN));
            quot_d  = dz ? '1 : ovf ? res_a : early ? '0 : quot_q;
            rem_d   = dz ? res_a : ovf ? '0 : early ? res_a : rem_q;
        end
        if (state_q == DIV_DIV) begin
            r_d   = r_step;
            q_d   = q_step;
            cnt_d = cnt_q - DIV_CNT_W'(1);
        end
        if (state_q == DIV_FIX) begin
            quot_d = word_q ? sext32(fq[31:0]) : fq;
            rem_d  = word_q ? sext32(fr[31:0]) : fr;
        end
        if (flush) begin
            cnt_d  = '0;
            quot_d = quot_q;
            rem_d  = rem_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= DIV_IDLE;
        else state_q <= state_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            word_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            word_q  <= word_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end
endmodule
